// File: rtl/pattern_game_engine.sv
// pattern_game_engine: memory-game FSM that grows, plays back and checks a random button sequence.
module pattern_game_engine #(
  parameter int NUM_BUTTONS = 8,
  parameter int MAX_LEN = 32,
  parameter int SHOW_CYCLES = 500,
  parameter int GAP_CYCLES = 250,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int LIVES = 3,
  parameter int SCORE_W = 6,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int IDX_W = $clog2(NUM_BUTTONS),
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] led,
  output logic                   active,
  output logic                   game_over,
  output logic                   win,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     high_score,
  output logic [2:0]             lives_left,
  output logic [LEN_W-1:0]       round_len
);
  localparam int SG = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX = SG > TIMEOUT_CYCLES ? SG : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, EXTEND, SHOW_ON, SHOW_OFF, INPUT, MISS, OVER, WIN} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic prs_q;
  logic [1:0] mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, exp_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d, high_q, high_d, score_inc;
  logic [2:0] lives_q, lives_d;
  logic [IDX_W-1:0] pat_q [2**LEN_W];
  logic press_ev, hit, last, show_end, gap_end, tmo_end, timed, full;
  assign exp_idx = (mode_q == 2'd1) ? len_q - LEN_W'(1) - idx_q : idx_q;
  assign hit = buttons == (NUM_BUTTONS'(1) << pat_q[exp_idx]);
  // Only a rising edge of "any button" counts, so a press held across the INPUT entry is ignored.
  assign press_ev = (|buttons) & ~prs_q;
  assign last = idx_q == len_q - LEN_W'(1);
  assign show_end = timer_q == TW'(SHOW_CYCLES - 1);
  assign gap_end = timer_q == TW'(GAP_CYCLES - 1);
  assign tmo_end = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign timed = mode_q == 2'd2;
  assign full = len_q == LEN_W'(MAX_LEN);
  assign score_inc = &score_q ? score_q : score_q + SCORE_W'(1);
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    state_d = state_q;
    mode_d = mode_q;
    len_d = len_q;
    idx_d = idx_q;
    timer_d = timer_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      EXTEND: begin
        len_d = len_q + LEN_W'(1);
        idx_d = '0;
        timer_d = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        timer_d = show_end ? '0 : timer_q + TW'(1);
        state_d = show_end ? SHOW_OFF : SHOW_ON;
      end
      SHOW_OFF: begin
        timer_d = gap_end ? '0 : timer_q + TW'(1);
        idx_d = gap_end ? (last ? '0 : idx_q + LEN_W'(1)) : idx_q;
        state_d = gap_end ? (last ? INPUT : SHOW_ON) : SHOW_OFF;
      end
      INPUT: begin
        if (press_ev && !hit) state_d = MISS;
        else if (press_ev) begin
          timer_d = '0;
          idx_d = idx_q + LEN_W'(1);
          score_d = last ? score_inc : score_q;
          state_d = last ? (full ? WIN : EXTEND) : INPUT;
        end
        else if (timed && tmo_end) state_d = MISS;
        else timer_d = timer_q + TW'(1);
      end
      MISS: begin
        lives_d = lives_q - 3'd1;
        idx_d = '0;
        timer_d = '0;
        state_d = (lives_q == 3'd1) ? OVER : SHOW_ON;
      end
      default: if (start) begin
        state_d = EXTEND;
        mode_d = mode;
        score_d = '0;
        len_d = '0;
        lives_d = 3'(LIVES);
      end
    endcase
    high_d = ((state_d == OVER || state_d == WIN) && state_q != OVER && state_q != WIN
              && score_d > high_q) ? score_d : high_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      prs_q <= 1'b0;
      mode_q <= 2'd0;
      len_q <= '0;
      idx_q <= '0;
      timer_q <= '0;
      score_q <= '0;
      high_q <= '0;
      lives_q <= 3'(LIVES);
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      prs_q <= |buttons;
      mode_q <= mode_d;
      len_q <= len_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
      score_q <= score_d;
      high_q <= high_d;
      lives_q <= lives_d;
    end
  end
  always_ff @(posedge clock) begin
    if (state_q == EXTEND) pat_q[len_q] <= lfsr_q[IDX_W-1:0];
  end
  assign led = (state_q == SHOW_ON) ? NUM_BUTTONS'(1) << pat_q[idx_q] : '0;
  assign active = state_q inside {EXTEND, SHOW_ON, SHOW_OFF, INPUT, MISS};
  assign game_over = state_q == OVER;
  assign win = state_q == WIN;
  assign score = score_q;
  assign high_score = high_q;
  assign lives_left = lives_q;
  assign round_len = len_q;
endmodule

// File: tb/tb_pattern_game_engine.sv
// tb_pattern_game_engine: directed games with a led-playback scoreboard and status checks.
module tb_pattern_game_engine;
  localparam int NB = 8, ML = 4, SC = 4, GC = 2, TO = 10;
  logic clock = 0, reset = 1, start = 0;
  logic [1:0] mode = 0;
  logic [NB-1:0] buttons = 0;
  logic [NB-1:0] led;
  logic active, game_over, win;
  logic [5:0] score, high_score;
  logic [2:0] lives_left;
  logic [2:0] round_len;
  pattern_game_engine #(.NUM_BUTTONS(NB), .MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
    .TIMEOUT_CYCLES(TO), .LIVES(3), .SCORE_W(6), .SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .buttons(buttons), .led(led),
    .active(active), .game_over(game_over), .win(win), .score(score), .high_score(high_score),
    .lives_left(lives_left), .round_len(round_len));
  always #5 clock = ~clock;
  logic [15:0] lfsr_m;
  always @(posedge clock or posedge reset)
    lfsr_m <= reset ? 16'hACE1 : ({1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000));
  int vectors = 0, miscompares = 0;
  logic [NB-1:0] exp_q[$];
  int pat[8];
  int len = 0;
  function automatic logic [NB-1:0] oh(input int i);
    return 8'(1) << i;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  initial begin
    int run = 0;
    forever begin
      @(negedge clock);
      if (reset) run = 0;
      else begin
        if (led != 0 && run == 0) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL led_unexpected: got %0h, expected dark", led);
          end else chk("led_value", int'(led), int'(exp_q.pop_front()));
        end
        if (led != 0) run++;
        else if (run != 0) begin
          chk("led_on_len", run, SC);
          run = 0;
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask
  task automatic replay(input logic [NB-1:0] hold);
    for (int i = 0; i < len; i++) exp_q.push_back(oh(pat[i]));
    tick();
    chk("round_len", int'(round_len), len);
    tick((SC + GC) * len - 1);
    buttons = hold;
    tick();
  endtask
  task automatic extend();
    pat[len] = int'(lfsr_m[2:0]);
    len++;
    replay('0);
  endtask
  task automatic press(input logic [NB-1:0] v, input bit last);
    buttons = v;
    tick();
    buttons = '0;
    if (!last) tick();
  endtask
  task automatic begin_game(input logic [1:0] m);
    start = 1;
    mode = m;
    tick();
    start = 0;
    mode = 2'd3;
    len = 0;
    chk("extend_active", int'(active), 1);
  endtask
  task automatic play(input bit rev);
    for (int j = 0; j < len; j++) press(oh(rev ? pat[len-1-j] : pat[j]), j == len - 1);
  endtask
  initial begin
    int w;
    tick(2);
    chk("rst_led", int'(led), 0);
    chk("rst_lives", int'(lives_left), 3);
    chk("rst_high", int'(high_score), 0);
    reset = 0;
    tick();
    chk("idle_active", int'(active), 0);
    chk("idle_len", int'(round_len), 0);
    begin_game(2'd0);
    for (int r = 1; r <= ML; r++) begin
      extend();
      play(0);
      if (r < ML) begin
        chk("classic_score", int'(score), r);
        chk("classic_lives", int'(lives_left), 3);
      end
    end
    chk("win_flag", int'(win), 1);
    chk("win_score", int'(score), 4);
    chk("win_high", int'(high_score), 4);
    chk("win_len", int'(round_len), 4);
    chk("win_active", int'(active), 0);
    begin_game(2'd2);
    extend();
    tick(TO - 1);
    press(oh(pat[0]), 1);
    chk("late_press_score", int'(score), 1);
    extend();
    for (int t = 0; t < 3; t++) begin
      tick(TO);
      chk("timeout_miss_lives", int'(lives_left), 3 - t);
      if (t < 2) begin
        replay('0);
        chk("timeout_lives_after", int'(lives_left), 2 - t);
      end
    end
    tick();
    chk("over_flag", int'(game_over), 1);
    chk("over_lives", int'(lives_left), 0);
    chk("over_score", int'(score), 1);
    chk("over_high", int'(high_score), 4);
    chk("over_len", int'(round_len), 2);
    chk("queue_empty", exp_q.size(), 0);
    begin_game(2'd1);
    extend();
    play(1);
    extend();
    play(1);
    chk("rev_score", int'(score), 2);
    extend();
    w = (pat[0] != pat[2]) ? pat[0] : (pat[2] + 1) % 8;
    press(oh(w), 1);
    chk("rev_miss_lives", int'(lives_left), 3);
    replay(oh((pat[2] + 1) % 8));
    tick(3);
    chk("held_no_event", int'(lives_left), 2);
    chk("held_active", int'(active), 1);
    buttons = '0;
    tick();
    play(1);
    chk("rev_score3", int'(score), 3);
    chk("rev_lives", int'(lives_left), 2);
    extend();
    press(oh(pat[3]) | oh((pat[3] + 1) % 8), 1);
    for (int i = 0; i < len; i++) exp_q.push_back(oh(pat[i]));
    tick(2);
    chk("multihot_lives", int'(lives_left), 1);
    chk("multihot_len", int'(round_len), 4);
    chk("pre_reset_high", int'(high_score), 4);
    reset = 1;
    #1;
    chk("async_led", int'(led), 0);
    chk("async_high", int'(high_score), 0);
    chk("async_active", int'(active), 0);
    chk("async_lives", int'(lives_left), 3);
    chk("async_len", int'(round_len), 0);
    exp_q.delete();
    tick(2);
    reset = 0;
    tick(2);
    chk("post_reset_score", int'(score), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
endmodule
